// File: rtl/dcom_buffer_writer_pkg.sv
// Shared widths, FSM state type and command record for the DCOM buffer writer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dcom_writer_pkg;

  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 64;
  localparam int BE_W      = DATA_W / 8;
  localparam int MAX_WORDS = 4096;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } t_dcom_writer_state;

  // Transfer command latched at start: first word address and word count.
  typedef struct packed {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   length;
  } t_dcom_writer_cmd;

endpackage

// File: rtl/dcom_buffer_writer_if.sv
// Upstream word stream plus Avalon-MM write master bundle for the DCOM buffer writer.
// Latency: n/a (wires only).
// Backpressure: snk_ready_o toward the stream, avm_waitrequest_i from the slave.
interface dcom_buffer_writer_if #(
  parameter int ADDR_W = dcom_writer_pkg::ADDR_W,
  parameter int DATA_W = dcom_writer_pkg::DATA_W,
  parameter int BE_W   = dcom_writer_pkg::BE_W
) ();

  // Upstream stream
  logic              snk_valid_i;
  logic [DATA_W-1:0] snk_data_i;
  logic [BE_W-1:0]   snk_be_i;
  logic              snk_last_i;
  logic              snk_ready_o;

  // Avalon-MM master toward the DCOM data buffer
  logic [ADDR_W-1:0] avm_address_o;
  logic              avm_write_o;
  logic [DATA_W-1:0] avm_writedata_o;
  logic [BE_W-1:0]   avm_byteenable_o;
  logic              avm_waitrequest_i;

  // Writer side
  modport master (
    input  snk_valid_i, snk_data_i, snk_be_i, snk_last_i, avm_waitrequest_i,
    output snk_ready_o, avm_address_o, avm_write_o, avm_writedata_o, avm_byteenable_o
  );

  // Environment side: stream source and buffer slave
  modport slave (
    output snk_valid_i, snk_data_i, snk_be_i, snk_last_i, avm_waitrequest_i,
    input  snk_ready_o, avm_address_o, avm_write_o, avm_writedata_o, avm_byteenable_o
  );

endinterface

// File: rtl/dcom_buffer_writer.sv
// Avalon-MM write master filling the DCOM data buffer from a word stream, one word per cycle.
// Latency: word accepted at M is on the bus at M+1; done pulses the cycle after the last write.
// Backpressure: waitrequest freezes the one-entry hold register, which drops snk_ready_o.
module dcom_buffer_writer #(
  parameter int ADDR_W = dcom_writer_pkg::ADDR_W,
  parameter int DATA_W = dcom_writer_pkg::DATA_W,
  parameter int BE_W   = dcom_writer_pkg::BE_W
) (
  input  logic              clock_sink_clk,
  input  logic              reset_sink_reset_n,
  input  logic              ctrl_start_i,
  input  logic              ctrl_abort_i,
  input  logic [ADDR_W-1:0] ctrl_base_addr_i,
  input  logic [ADDR_W:0]   ctrl_length_i,
  output logic              status_busy_o,
  output logic              status_done_o,
  output logic              status_aborted_o,
  output logic              status_err_o,
  output logic [ADDR_W:0]   status_words_o,
  dcom_buffer_writer_if.master bus
);
  import dcom_writer_pkg::*;

  localparam int LEN_W = ADDR_W + 1;

  t_dcom_writer_state state_q, state_d;
  t_dcom_writer_cmd   cmd_q, cmd_d;
  logic [LEN_W-1:0]   acc_q, acc_d;       // words taken from the stream
  logic [LEN_W-1:0]   words_q, words_d;   // writes completed on the bus
  logic               hold_vld_q, hold_vld_d;
  logic [DATA_W-1:0]  hold_dat_q, hold_dat_d;
  logic [BE_W-1:0]    hold_be_q, hold_be_d;
  logic               abort_req_q, abort_req_d;
  logic               aborted_q, aborted_d;
  logic               err_q, err_d;

  logic len_ok;
  logic wr_done;
  logic snk_accept;

  assign len_ok  = (ctrl_length_i != '0) && (ctrl_length_i <= LEN_W'(MAX_WORDS));
  assign wr_done = hold_vld_q && !bus.avm_waitrequest_i;

  // The hold slot may refill in the same cycle its write completes, giving full throughput.
  assign bus.snk_ready_o = (state_q == ST_RUN) && (acc_q < cmd_q.length) &&
                           (!hold_vld_q || wr_done) && !ctrl_abort_i;
  assign snk_accept      = bus.snk_valid_i && bus.snk_ready_o;

  // Next-state and datapath: command latch, hold register, counters, end/abort handling.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    acc_d       = acc_q;
    words_d     = words_q;
    hold_vld_d  = hold_vld_q;
    hold_dat_d  = hold_dat_q;
    hold_be_d   = hold_be_q;
    abort_req_d = abort_req_q;
    aborted_d   = aborted_q;
    err_d       = 1'b0;

    if (wr_done) begin
      hold_vld_d = 1'b0;
      words_d    = words_q + 1'b1;
    end
    if (snk_accept) begin
      hold_vld_d = 1'b1;
      hold_dat_d = bus.snk_data_i;
      hold_be_d  = bus.snk_be_i;
      acc_d      = acc_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        // Abort alongside start cancels the command outright.
        if (ctrl_start_i && !ctrl_abort_i) begin
          if (len_ok) begin
            cmd_d.base   = ctrl_base_addr_i;
            cmd_d.length = ctrl_length_i;
            acc_d        = '0;
            words_d      = '0;
            abort_req_d  = 1'b0;
            aborted_d    = 1'b0;
            state_d      = ST_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (ctrl_abort_i) begin
          // A write already on the bus cannot be withdrawn; let it finish in DRAIN.
          abort_req_d = 1'b1;
          if (!hold_vld_q || wr_done) begin
            aborted_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            state_d = ST_DRAIN;
          end
        end else if (snk_accept && (bus.snk_last_i || (acc_q + 1'b1) == cmd_q.length)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (ctrl_abort_i) abort_req_d = 1'b1;
        if (!hold_vld_q || wr_done) begin
          aborted_d = abort_req_q || ctrl_abort_i;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset clears everything, so a pending write drops immediately.
  always_ff @(posedge clock_sink_clk or negedge reset_sink_reset_n) begin
    if (!reset_sink_reset_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      acc_q       <= '0;
      words_q     <= '0;
      hold_vld_q  <= 1'b0;
      hold_dat_q  <= '0;
      hold_be_q   <= '0;
      abort_req_q <= 1'b0;
      aborted_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      acc_q       <= acc_d;
      words_q     <= words_d;
      hold_vld_q  <= hold_vld_d;
      hold_dat_q  <= hold_dat_d;
      hold_be_q   <= hold_be_d;
      abort_req_q <= abort_req_d;
      aborted_q   <= aborted_d;
      err_q       <= err_d;
    end
  end

  // Offset is the completed-write count, so the address holds still during a stall.
  assign bus.avm_write_o      = hold_vld_q;
  assign bus.avm_address_o    = cmd_q.base + words_q[ADDR_W-1:0];
  assign bus.avm_writedata_o  = hold_dat_q;
  assign bus.avm_byteenable_o = hold_be_q;

  assign status_busy_o    = (state_q != ST_IDLE);
  assign status_done_o    = (state_q == ST_DONE);
  assign status_aborted_o = aborted_q;
  assign status_err_o     = err_q;
  assign status_words_o   = words_q;

endmodule

// File: tb/tb_dcom_buffer_writer.sv
// Randomised bench for dcom_buffer_writer with a transfer-level reference model.
// Latency: checks accept-to-write, last-write-to-done and start-to-busy timing.
// Backpressure: drives random and forced waitrequest stalls and checks bus stability.
`timescale 1ns/1ps
module tb_dcom_buffer_writer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start, abort;
  logic [11:0] base;
  logic [12:0] length;
  logic        busy, done, aborted, err;
  logic [12:0] words;

  dcom_buffer_writer_if bus ();

  dcom_buffer_writer dut (
    .clock_sink_clk     (clk),
    .reset_sink_reset_n (rst_n),
    .ctrl_start_i       (start),
    .ctrl_abort_i       (abort),
    .ctrl_base_addr_i   (base),
    .ctrl_length_i      (length),
    .status_busy_o      (busy),
    .status_done_o      (done),
    .status_aborted_o   (aborted),
    .status_err_o       (err),
    .status_words_o     (words),
    .bus                (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [11:0] a;
    logic [63:0] d;
    logic [7:0]  be;
    int          cyc;
  } wr_t;

  wr_t         wr_q[$];
  int          acc_n, done_cnt, err_cnt, cyc;
  logic [63:0] sd[4096];
  logic [7:0]  sb[4096];

  logic        prev_stall, prev_acc, prev_wc, prev_done;
  logic [11:0] p_a;
  logic [63:0] p_d;
  logic [7:0]  p_be;

  // Bus monitor: logs accepts and completed writes, checks cycle-level rules.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0; prev_acc = 1'b0; prev_wc = 1'b0; prev_done = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_write", 64'(bus.avm_write_o), 64'(1));
        check("stall_addr",  64'(bus.avm_address_o), 64'(p_a));
        check("stall_data",  bus.avm_writedata_o, p_d);
        check("stall_be",    64'(bus.avm_byteenable_o), 64'(p_be));
      end
      if (prev_acc)  check("accept_to_write", 64'(bus.avm_write_o), 64'(1));
      if (prev_done) check("busy_after_done", 64'(busy), 64'(0));
      if (done) begin
        done_cnt++;
        check("done_after_write", 64'(prev_wc), 64'(1));
      end
      if (err) err_cnt++;
      if (bus.avm_write_o && bus.avm_waitrequest_i)
        check("ready_in_stall", 64'(bus.snk_ready_o), 64'(0));
      if (bus.snk_valid_i && bus.snk_ready_o) acc_n++;
      if (bus.avm_write_o && !bus.avm_waitrequest_i)
        wr_q.push_back('{a: bus.avm_address_o, d: bus.avm_writedata_o,
                         be: bus.avm_byteenable_o, cyc: cyc});
      prev_stall = bus.avm_write_o && bus.avm_waitrequest_i;
      prev_acc   = bus.snk_valid_i && bus.snk_ready_o;
      prev_wc    = bus.avm_write_o && !bus.avm_waitrequest_i;
      prev_done  = done;
      p_a  = bus.avm_address_o;
      p_d  = bus.avm_writedata_o;
      p_be = bus.avm_byteenable_o;
    end
  end

  task automatic idle_inputs();
    start = 1'b0; abort = 1'b0;
    bus.snk_valid_i = 1'b0; bus.snk_data_i = '0; bus.snk_be_i = '0;
    bus.snk_last_i = 1'b0; bus.avm_waitrequest_i = 1'b0;
  endtask

  // One transfer: expected writes are the first min(n, last_at) stream words (or the
  // first stall_word words when aborted) at (b + i) mod 4096, in order.
  task automatic xfer(input string name, input logic [11:0] b, input int n, input int last_at,
                      input int vpct, input int wpct, input int stall_word, input int stall_len,
                      input bit do_abort, input bit spurious);
    int slen, exp_n, scnt, budget, k, cycles;
    bit timed_out;
    logic [11:0] ea;
    slen   = (last_at > 0 && last_at < n) ? last_at : n;
    exp_n  = do_abort ? stall_word : slen;
    budget = n * 30 + 100;
    for (int i = 0; i < n; i++) begin
      sd[i] = {$urandom, $urandom};
      sb[i] = 8'($urandom);
    end
    wr_q.delete(); acc_n = 0; done_cnt = 0; err_cnt = 0; scnt = 0;
    @(posedge clk); #1;
    start = 1'b1; base = b; length = 13'(n);
    @(posedge clk); #1;
    start = 1'b0;
    check({name, ":busy_after_start"},  64'(busy), 64'(1));
    check({name, ":ready_after_start"}, 64'(bus.snk_ready_o), 64'(1));
    cycles = 0; timed_out = 1'b0;
    while (done_cnt == 0) begin
      k = acc_n;
      bus.snk_valid_i = (k < slen) && ($urandom_range(0, 99) < vpct);
      bus.snk_data_i  = (k < slen) ? sd[k] : '0;
      bus.snk_be_i    = (k < slen) ? sb[k] : '0;
      bus.snk_last_i  = (k + 1 == last_at);
      abort = 1'b0;
      if (bus.avm_write_o && (wr_q.size() + 1 == stall_word) && scnt < stall_len) begin
        bus.avm_waitrequest_i = 1'b1;
        if (do_abort && scnt == 1) abort = 1'b1;
        scnt++;
      end else begin
        bus.avm_waitrequest_i = ($urandom_range(0, 99) < wpct);
      end
      start = spurious && (cycles == 2);
      if (start) begin length = 13'd0; base = ~b; end
      @(posedge clk); #1;
      cycles++;
      if (cycles > budget) begin timed_out = 1'b1; break; end
    end
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check({name, ":timeout"},  64'(timed_out), 64'(0));
    check({name, ":words"},    64'(words), 64'(exp_n));
    check({name, ":accepted"}, 64'(acc_n), 64'(exp_n));
    check({name, ":writes"},   64'(wr_q.size()), 64'(exp_n));
    check({name, ":done_cnt"}, 64'(done_cnt), 64'(1));
    check({name, ":aborted"},  64'(aborted), 64'(do_abort));
    check({name, ":err_cnt"},  64'(err_cnt), 64'(0));
    check({name, ":busy_end"}, 64'(busy), 64'(0));
    for (int i = 0; i < wr_q.size() && i < exp_n; i++) begin
      ea = b + 12'(i);
      check({name, ":addr"}, 64'(wr_q[i].a), 64'(ea));
      check({name, ":data"}, wr_q[i].d, sd[i]);
      check({name, ":be"},   64'(wr_q[i].be), 64'(sb[i]));
      if (vpct == 100 && wpct == 0 && stall_len == 0 && i > 0)
        check({name, ":back_to_back"}, 64'(wr_q[i].cyc - wr_q[i-1].cyc), 64'(1));
    end
  endtask

  task automatic bad_start(input string name, input logic [12:0] len, input bit with_abort,
                           input bit exp_err);
    err_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; length = len; base = 12'h123; abort = with_abort;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check({name, ":err"},  64'(err), 64'(exp_err));
    check({name, ":busy"}, 64'(busy), 64'(0));
    @(posedge clk); #1;
    check({name, ":err_pulse"}, 64'(err), 64'(0));
    check({name, ":busy2"},     64'(busy), 64'(0));
    check({name, ":err_cnt"},   64'(err_cnt), 64'(exp_err));
  endtask

  initial begin
    int n, la;
    idle_inputs();
    base = '0; length = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst:busy",    64'(busy), 64'(0));
    check("rst:done",    64'(done), 64'(0));
    check("rst:aborted", 64'(aborted), 64'(0));
    check("rst:err",     64'(err), 64'(0));
    check("rst:words",   64'(words), 64'(0));
    check("rst:write",   64'(bus.avm_write_o), 64'(0));
    check("rst:ready",   64'(bus.snk_ready_o), 64'(0));
    check("rst:addr",    64'(bus.avm_address_o), 64'(0));
    check("rst:data",    bus.avm_writedata_o, 64'(0));
    check("rst:be",      64'(bus.avm_byteenable_o), 64'(0));
    rst_n = 1'b1;

    xfer("basic",    12'h010, 4, 0, 100, 0, 0, 0, 1'b0, 1'b0);
    xfer("stall",    12'h100, 4, 0, 100, 0, 2, 3, 1'b0, 1'b1);
    xfer("wrap",     12'hFFE, 8, 3, 100, 0, 0, 0, 1'b0, 1'b0);
    xfer("abort",    12'h300, 8, 0, 100, 0, 5, 3, 1'b1, 1'b0);
    xfer("post_abt", 12'h040, 2, 0, 100, 0, 0, 0, 1'b0, 1'b0);

    bad_start("len0",       13'd0,    1'b0, 1'b1);
    bad_start("len4097",    13'd4097, 1'b0, 1'b1);
    bad_start("len8191",    13'd8191, 1'b0, 1'b1);
    bad_start("start_abt",  13'd4,    1'b1, 1'b0);
    bad_start("start_abt0", 13'd0,    1'b1, 1'b0);

    // Reset in the middle of a running transfer
    @(posedge clk); #1;
    start = 1'b1; base = 12'h200; length = 13'd8;
    @(posedge clk); #1;
    start = 1'b0;
    bus.snk_valid_i = 1'b1; bus.snk_data_i = {$urandom, $urandom}; bus.snk_be_i = 8'hFF;
    repeat (3) @(posedge clk);
    #3;
    check("midrst:write_before", 64'(bus.avm_write_o), 64'(1));
    rst_n = 1'b0;
    #1;
    check("midrst:write", 64'(bus.avm_write_o), 64'(0));
    check("midrst:busy",  64'(busy), 64'(0));
    check("midrst:words", 64'(words), 64'(0));
    check("midrst:ready", 64'(bus.snk_ready_o), 64'(0));
    check("midrst:done",  64'(done), 64'(0));
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    xfer("after_rst", 12'h200, 4, 0, 100, 0, 0, 0, 1'b0, 1'b0);

    for (int t = 0; t < 10; t++) begin
      n  = $urandom_range(1, 12);
      la = ($urandom_range(0, 1) != 0) ? $urandom_range(1, n) : 0;
      xfer("rand", 12'($urandom), n, la, 60, 30, 0, 0, 1'b0, 1'b0);
    end

    xfer("max_len", 12'($urandom), 4096, 0, 90, 10, 0, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
